// File: rtl/muldiv_iter_pkg.sv
// Shared control definitions for the iterative RV32M multiply/divide unit.
//   sel_md_op_e : operation select produced by the decoder
//   md_state_e  : control FSM state of muldiv_iter
//   MD_ITER     : number of radix-2 iterations for a full-width operation
package muldiv_iter_pkg;

  typedef enum logic [2:0] {
    muldiv_nop = 3'd0,
    mull       = 3'd1,
    mulh       = 3'd2,
    div        = 3'd3,
    rem        = 3'd4
  } sel_md_op_e;

  typedef enum logic [1:0] {
    md_idle = 2'd0,
    md_calc = 2'd1,
    md_done = 2'd2
  } md_state_e;

  localparam int MD_ITER = 32;

  function automatic logic md_is_div(input sel_md_op_e op);
    return (op == div) || (op == rem);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate.
//   val_i : input value
//   neg_i : 1 -> output is -val_i, 0 -> output is val_i
//   val_o : result (same width as val_i)
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide unit (RV32M), one bit per cycle.
//   p_clk_i, p_reset_i          : clock, synchronous active-high reset
//   p_start_i, p_op_i           : request strobe and sel_md_op_e select
//   p_signed_a_i, p_signed_b_i  : operand signedness
//   p_opa_i, p_opb_i            : multiplicand/dividend, multiplier/divisor
//   p_flush_i                   : abort the operation in flight
//   p_busy_o, p_done_o          : busy in CALC/DONE, one-cycle done pulse
//   p_result_o                  : result, held until the next completion
//
// Handshake: a request is accepted on a rising edge where the unit is idle,
// p_start_i=1, p_op_i!=muldiv_nop and p_flush_i=0; otherwise it is dropped
// (there is no ready/retry). p_busy_o is high from the cycle after acceptance
// through the done cycle; p_done_o marks the single cycle in which a freshly
// written p_result_o is presented. A flush cancels without a done pulse.
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            p_clk_i,
  input  logic            p_reset_i,
  input  logic            p_start_i,
  input  logic [2:0]      p_op_i,
  input  logic            p_signed_a_i,
  input  logic            p_signed_b_i,
  input  logic [XLEN-1:0] p_opa_i,
  input  logic [XLEN-1:0] p_opb_i,
  input  logic            p_flush_i,
  output logic            p_busy_o,
  output logic            p_done_o,
  output logic [XLEN-1:0] p_result_o
);

  localparam int              CW        = $clog2(MD_ITER);
  localparam logic [CW-1:0]   LAST_ITER = CW'(MD_ITER - 1);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  sel_md_op_e        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   operand_q, operand_d;   // |a| for mul, |b| (divisor) for div
  logic [2*XLEN-1:0] acc_q, acc_d;           // mul: {partial, multiplier}; div: {rem, quotient}
  logic              neg_prod_q, neg_prod_d; // product / quotient sign
  logic              neg_rem_q, neg_rem_d;   // remainder sign (dividend sign)
  logic              special_q, special_d;
  logic [XLEN-1:0]   spec_res_q, spec_res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  // ---- request decode ----
  sel_md_op_e      op_in;
  logic            in_div, sa_eff, sb_eff, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, spec_in;

  assign op_in  = sel_md_op_e'(p_op_i);
  assign in_div = md_is_div(op_in);
  // Division is signed only when both flags are set; mixed flags mean unsigned.
  assign sa_eff = in_div ? (p_signed_a_i & p_signed_b_i) : p_signed_a_i;
  assign sb_eff = in_div ? (p_signed_a_i & p_signed_b_i) : p_signed_b_i;
  assign a_neg  = sa_eff & p_opa_i[XLEN-1];
  assign b_neg  = sb_eff & p_opb_i[XLEN-1];

  md_sign_fix #(.W(XLEN)) u_mag_a (.val_i(p_opa_i), .neg_i(a_neg), .val_o(mag_a));
  md_sign_fix #(.W(XLEN)) u_mag_b (.val_i(p_opb_i), .neg_i(b_neg), .val_o(mag_b));

  assign div_zero = (p_opb_i == '0);
  assign div_ovf  = sa_eff & (p_opa_i == INT_MIN) & (p_opb_i == '1);
  always_comb begin
    spec_in = '0;
    if (div_zero)     spec_in = (op_in == div) ? '1 : p_opa_i;
    else if (div_ovf) spec_in = (op_in == div) ? INT_MIN : '0;
  end

  // ---- one iteration step ----
  logic [XLEN:0]     mul_sum, rem_sh;
  logic [XLEN-1:0]   rem_sub;
  logic              div_fits;
  logic [2*XLEN-1:0] mul_next, div_next, step_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, operand_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor only when it fits. rem_sh < divisor whenever it does
  // not fit, so its top bit is zero in that branch.
  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_fits = (rem_sh >= {1'b0, operand_q});
  assign rem_sub  = rem_sh[XLEN-1:0] - operand_q;
  assign div_next = div_fits ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
                             : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

  assign step_next = md_is_div(op_q) ? div_next : mul_next;

  // ---- sign correction of the final step's output ----
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  md_sign_fix #(.W(2*XLEN)) u_fix_prod (.val_i(mul_next), .neg_i(neg_prod_q), .val_o(prod_fix));
  md_sign_fix #(.W(XLEN)) u_fix_quo (.val_i(div_next[XLEN-1:0]), .neg_i(neg_prod_q), .val_o(quo_fix));
  md_sign_fix #(.W(XLEN)) u_fix_rem (.val_i(div_next[2*XLEN-1:XLEN]), .neg_i(neg_rem_q), .val_o(rem_fix));

  always_comb begin
    case (op_q)
      mull:    final_res = prod_fix[XLEN-1:0];
      mulh:    final_res = prod_fix[2*XLEN-1:XLEN];
      div:     final_res = quo_fix;
      default: final_res = rem_fix;
    endcase
  end

  // ---- control ----
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    operand_d  = operand_q;
    acc_d      = acc_q;
    neg_prod_d = neg_prod_q;
    neg_rem_d  = neg_rem_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    case (state_q)
      md_idle: begin
        if (p_start_i && !p_flush_i && (op_in != muldiv_nop)) begin
          state_d    = md_calc;
          busy_d     = 1'b1;
          op_d       = op_in;
          cnt_d      = '0;
          operand_d  = in_div ? mag_b : mag_a;
          acc_d      = {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
          neg_prod_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          special_d  = in_div & (div_zero | div_ovf);
          spec_res_d = spec_in;
        end
      end
      md_calc: begin
        if (p_flush_i) begin
          state_d = md_idle;
          busy_d  = 1'b0;
        end else if (special_q) begin
          state_d  = md_done;
          done_d   = 1'b1;
          result_d = spec_res_q;
        end else begin
          acc_d = step_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            state_d  = md_done;
            done_d   = 1'b1;
            result_d = final_res;
          end
        end
      end
      default: begin
        state_d = md_idle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge p_clk_i) begin
    if (p_reset_i) begin
      state_q    <= md_idle;
      op_q       <= muldiv_nop;
      cnt_q      <= '0;
      operand_q  <= '0;
      acc_q      <= '0;
      neg_prod_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      operand_q  <= operand_d;
      acc_q      <= acc_d;
      neg_prod_q <= neg_prod_d;
      neg_rem_q  <= neg_rem_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign p_busy_o   = busy_q;
  assign p_done_o   = done_q;
  assign p_result_o = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;
  import muldiv_iter_pkg::*;

  // ---- clock / reset / DUT ----
  logic        clk = 1'b0;
  logic        p_reset_i = 1'b1;
  logic        p_start_i = 1'b0;
  logic [2:0]  p_op_i = 3'd0;
  logic        p_signed_a_i = 1'b0;
  logic        p_signed_b_i = 1'b0;
  logic [31:0] p_opa_i = '0;
  logic [31:0] p_opb_i = '0;
  logic        p_flush_i = 1'b0;
  logic        p_busy_o, p_done_o;
  logic [31:0] p_result_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_iter #(.XLEN(32)) dut (
    .p_clk_i(clk), .p_reset_i(p_reset_i), .p_start_i(p_start_i), .p_op_i(p_op_i),
    .p_signed_a_i(p_signed_a_i), .p_signed_b_i(p_signed_b_i),
    .p_opa_i(p_opa_i), .p_opb_i(p_opb_i), .p_flush_i(p_flush_i),
    .p_busy_o(p_busy_o), .p_done_o(p_done_o), .p_result_o(p_result_o)
  );

  // ---- scoreboard state ----
  logic [31:0] exp_q[$];      // expected results, in issue order
  int          exp_acc_q[$];  // edge on which each request is accepted
  int          exp_cyc_q[$];  // edge after which done must be visible
  logic [31:0] model_result = '0;
  logic        check_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---- behavioural reference: plain 64-bit / integer arithmetic ----
  function automatic logic [31:0] model(input logic [2:0] op, input logic sa, input logic sb,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      av, bv, p;
    logic [63:0] pb;
    int          qs, rs;
    if (op == 3'(mull)) begin
      pb = 64'(a) * 64'(b);
      return pb[31:0];
    end
    if (op == 3'(mulh)) begin
      av = sa ? longint'($signed(a)) : longint'({32'b0, a});
      bv = sb ? longint'($signed(b)) : longint'({32'b0, b});
      p  = av * bv;
      pb = p;
      return pb[63:32];
    end
    if (b == 32'd0) return (op == 3'(div)) ? 32'hFFFF_FFFF : a;
    if (sa && sb) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return (op == 3'(div)) ? 32'h8000_0000 : 32'd0;
      qs = $signed(a) / $signed(b);
      rs = $signed(a) % $signed(b);
      return (op == 3'(div)) ? qs : rs;
    end
    return (op == 3'(div)) ? (a / b) : (a % b);
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic sa, input logic sb,
                                input logic [31:0] a, input logic [31:0] b);
    if ((op == 3'(div) || op == 3'(rem)) &&
        (b == 32'd0 || (sa && sb && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 32;
  endfunction

  // ---- compare process: every cycle once out of reset ----
  always @(negedge clk) begin
    if (check_en) begin
      logic exp_busy, exp_done;
      exp_busy = (exp_q.size() > 0) && (cyc >= exp_acc_q[0]);
      exp_done = (exp_q.size() > 0) && (cyc == exp_cyc_q[0]);
      check("busy", {31'b0, p_busy_o}, {31'b0, exp_busy});
      check("done", {31'b0, p_done_o}, {31'b0, exp_done});
      if (exp_done) begin
        check("result", p_result_o, exp_q[0]);
        model_result = exp_q.pop_front();
        void'(exp_acc_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end else begin
        check("result_hold", p_result_o, model_result);
      end
    end
  end

  // ---- driver tasks (inputs change 1 time unit after the rising edge) ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_acc_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic drive(input logic [2:0] op, input logic sa, input logic sb,
                       input logic [31:0] a, input logic [31:0] b);
    p_op_i = op; p_signed_a_i = sa; p_signed_b_i = sb; p_opa_i = a; p_opb_i = b;
  endtask

  // Issue one request to an idle unit and record what it must produce.
  task automatic start_op(input logic [2:0] op, input logic sa, input logic sb,
                          input logic [31:0] a, input logic [31:0] b);
    drive(op, sa, sb, a, b);
    p_start_i = 1'b1;
    exp_q.push_back(model(op, sa, sb, a, b));
    exp_acc_q.push_back(cyc + 1);
    exp_cyc_q.push_back(cyc + 1 + lat_of(op, sa, sb, a, b));
    tick();
    p_start_i = 1'b0;
  endtask

  // Start strobe the unit must ignore (busy, nop, or flushed).
  task automatic stray_start(input logic [2:0] op, input logic flush);
    drive(op, 1'b1, 1'b0, $urandom, $urandom);
    p_start_i = 1'b1;
    p_flush_i = flush;
    tick();
    p_start_i = 1'b0;
    p_flush_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      check("done_timeout", 32'(exp_q.size()), 32'd0);
      clear_model();
    end
  endtask

  task automatic do_reset();
    p_reset_i = 1'b1;
    tick();
    p_reset_i = 1'b0;
    clear_model();
    model_result = '0;
  endtask

  task automatic do_flush();
    p_flush_i = 1'b1;
    tick();
    p_flush_i = 1'b0;
    clear_model();
  endtask

  // ---- directed vectors with hand-computed results ----
  typedef struct {
    logic [2:0]  op;
    logic        sa, sb;
    logic [31:0] a, b, r;
  } vec_t;
  vec_t dir[12];

  initial begin
    dir[0]  = '{3'(mull), 1'b1, 1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    dir[1]  = '{3'(mull), 1'b0, 1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    dir[2]  = '{3'(mulh), 1'b0, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    dir[3]  = '{3'(mulh), 1'b1, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
    dir[4]  = '{3'(mulh), 1'b1, 1'b0, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
    dir[5]  = '{3'(div),  1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    dir[6]  = '{3'(rem),  1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    dir[7]  = '{3'(div),  1'b0, 1'b0, 32'd100,        32'd7,         32'd14};
    dir[8]  = '{3'(rem),  1'b0, 1'b0, 32'd100,        32'd7,         32'd2};
    dir[9]  = '{3'(div),  1'b0, 1'b0, 32'h1234,       32'd0,         32'hFFFF_FFFF};
    dir[10] = '{3'(rem),  1'b0, 1'b0, 32'h1234,       32'd0,         32'h1234};
    dir[11] = '{3'(div),  1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
  end

  // ---- main sequence ----
  initial begin
    logic [2:0]  op;
    logic        sa, sb;
    logic [31:0] a, b;

    tick();
    tick();
    p_reset_i = 1'b0;
    clear_model();
    model_result = '0;
    check_en = 1'b1;

    // Directed: pin the model against literals, then run each through the DUT.
    for (int i = 0; i < 12; i++) begin
      check("model_pin", model(dir[i].op, dir[i].sa, dir[i].sb, dir[i].a, dir[i].b), dir[i].r);
      start_op(dir[i].op, dir[i].sa, dir[i].sb, dir[i].a, dir[i].b);
      wait_idle();
    end
    check("model_pin_rem_ovf", model(3'(rem), 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
    start_op(3'(rem), 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();

    // Back-to-back: the next start goes in the idle cycle right after done.
    start_op(3'(mull), 1'b0, 1'b0, 32'd12345, 32'd678);
    wait_idle();
    start_op(3'(mulh), 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    wait_idle();

    // Nop start and start+flush in idle are dropped.
    stray_start(3'(muldiv_nop), 1'b0);
    tick();
    stray_start(3'(mull), 1'b1);
    tick();

    // Starts while in CALC and in DONE are ignored.
    start_op(3'(div), 1'b0, 1'b0, 32'd1000, 32'd3);
    tick(); tick(); tick();
    stray_start(3'(mull), 1'b0);
    for (int i = 0; i < 40 && exp_cyc_q.size() > 0 && cyc < exp_cyc_q[0]; i++) tick();
    stray_start(3'(mulh), 1'b0);
    wait_idle();

    // Flush at CALC cycle 10, then a new start one cycle later.
    start_op(3'(mulh), 1'b1, 1'b1, 32'h7654_3210, 32'h8123_4567);
    for (int i = 0; i < 10; i++) tick();
    do_flush();
    start_op(3'(rem), 1'b1, 1'b1, 32'hFFFF_FC00, 32'd7);
    wait_idle();

    // Flush of a special-case op while in CALC.
    start_op(3'(div), 1'b0, 1'b0, 32'd55, 32'd0);
    do_flush();
    tick();

    // Reset at CALC cycle 5 clears everything.
    start_op(3'(div), 1'b1, 1'b1, 32'h8765_4321, 32'd9);
    for (int i = 0; i < 5; i++) tick();
    do_reset();
    tick();

    // Randomized operations with occasional special cases and stray starts.
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(1, 4));
      sa = 1'($urandom);
      sb = 1'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; sa = 1'b1; sb = 1'b1; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      start_op(op, sa, sb, a, b);
      if (i % 25 == 7) stray_start(3'($urandom_range(1, 4)), 1'b0);
      wait_idle();
    end

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
